alu_issue_ctrl: RTL and testbench

Instruction-issue and write-back controller sitting in front of the execution ALU. It buffers incoming operation requests in a small FIFO and owns the 32-bit accumulator register. For each request it drives accumulator, operand and opcode into the ALU, waits for the ALU's registered result, and writes that result back into the accumulator. It is the issuing end of the ALU's acc/data/opcode → acc1 interface.

---
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Purpose : issue controller for the execution ALU. It queues requests in a small FIFO,
//           drives acc/data/opcode into the ALU and writes its result back into the accumulator.
// Latency : a push into an idle, empty unit shows up on acc_out 3 cycles later. Back-to-back
//           requests write back once every 2 cycles.
// Backpressure: instr_ready = !full. It depends only on the FIFO count and never on instr_valid.
//
// Ports:
//   execlk, rst_n                      clock and asynchronous active-low reset
//   instr_valid/instr_ready            request handshake
//   instr_opcode, instr_data           request payload (opcode, operand or load value)
//   alu_acc, alu_data, alu_opcode      outputs to the ALU (acc, data, opcode)
//   alu_result                         ALU acc1, which the ALU registers on execlk
//   acc_out, done, busy                accumulator, write-back pulse, activity flag
//   zero_flag                          present only when ALU_ISSUE_ZFLAG_EN is defined
//
// Build option ALU_ISSUE_ZFLAG_EN: adds the registered zero_flag output, which resets to 1.
module alu_issue_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  LDA_OP = 4'hF
) (
  input  logic        execlk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_opcode,
  input  logic [31:0] instr_data,
  output logic [31:0] alu_acc,
  output logic [31:0] alu_data,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  output logic [31:0] acc_out,
  output logic        done,
  output logic        busy
`ifdef ALU_ISSUE_ZFLAG_EN
  ,
  output logic        zero_flag
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e        state_q;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   alu_data_q;
  logic [3:0]    alu_opcode_q;
  logic          done_q;

  logic [3:0]    op_mem_q  [DEPTH];
  logic [31:0]   dat_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  // The full check uses the registered count, so a pop on the same edge cannot
  // make room for a push.
  assign push       = instr_valid && !fifo_full;
  assign pop        = ((state_q == IDLE) || (state_q == WB)) && !fifo_empty;

  // LDA is resolved here. For that opcode the ALU result is ignored.
  assign acc_d = (alu_opcode_q == LDA_OP) ? alu_data_q : alu_result;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
  end

  // The storage array is not reset. Entries are only read after they are written.
  always_ff @(posedge execlk) begin
    if (push) begin
      op_mem_q[wr_ptr_q]  <= instr_opcode;
      dat_mem_q[wr_ptr_q] <= instr_data;
    end
  end

  always_ff @(posedge execlk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Issue / write-back FSM. All ALU-facing outputs are registered here. The
  // accumulator changes only on the edge that leaves WB, so a pop on that same
  // edge lets the next instruction see the new value during its EXEC cycle.
  always_ff @(posedge execlk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      alu_data_q   <= '0;
      alu_opcode_q <= 4'b0000;
      done_q       <= 1'b0;
`ifdef ALU_ISSUE_ZFLAG_EN
      zero_flag    <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        alu_opcode_q <= op_mem_q[rd_ptr_q];
        alu_data_q   <= dat_mem_q[rd_ptr_q];
      end
      case (state_q)
        IDLE: if (pop) state_q <= EXEC;
        EXEC: state_q <= WB;   // the ALU samples the held operands on this edge
        WB: begin
          acc_q   <= acc_d;
          done_q  <= 1'b1;
`ifdef ALU_ISSUE_ZFLAG_EN
          zero_flag <= (acc_d == 32'd0);
`endif
          state_q <= pop ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = !fifo_full;
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign alu_acc     = acc_q;
  assign acc_out     = acc_q;
  assign alu_data    = alu_data_q;
  assign alu_opcode  = alu_opcode_q;
  assign done        = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl. Every accepted request pushes the
// hand-computed accumulator value it should produce. A monitor pops one entry on
// each done pulse and compares it with acc_out (and with zero_flag when enabled).
module tb_alu_issue_ctrl;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_UNM = 4'hA;
  localparam logic [3:0] OP_LDA = 4'hF;

  logic        execlk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [3:0]  instr_opcode = 4'h0;
  logic [31:0] instr_data = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        instr_ready, done, busy;
  logic [31:0] alu_acc, alu_data, acc_out;
  logic [3:0]  alu_opcode;
`ifdef ALU_ISSUE_ZFLAG_EN
  logic        zero_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int prev_done_cyc = -100;
  int last_gap = 0;
  int first_stall = 0;
  int push_idx = 0;
  int done_snap = 0;

  alu_issue_ctrl #(.DEPTH(4), .LDA_OP(4'hF)) dut (
    .execlk(execlk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_data(instr_data),
    .alu_acc(alu_acc), .alu_data(alu_data), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .acc_out(acc_out), .done(done), .busy(busy)
`ifdef ALU_ISSUE_ZFLAG_EN
    , .zero_flag(zero_flag)
`endif
  );

  always #5 execlk = ~execlk;
  always @(posedge execlk) cyc <= cyc + 1;

  // Reference ALU: ADD, SUB, and any other opcode passes the accumulator
  // through. The result is registered on execlk.
  always @(posedge execlk) begin
    case (alu_opcode)
      OP_ADD:  alu_result <= alu_acc + alu_data;
      OP_SUB:  alu_result <= alu_acc - alu_data;
      default: alu_result <= alu_acc;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: each write-back must match the oldest outstanding expectation.
  always @(negedge execlk) begin
    if (rst_n && done) begin
      logic [31:0] e;
      done_cnt++;
      last_gap = cyc - prev_done_cyc;
      prev_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: acc_out=%h with no write-back expected", acc_out);
      end else begin
        e = exp_q.pop_front();
        chk("wb_acc", acc_out, e);
`ifdef ALU_ISSUE_ZFLAG_EN
        chk("wb_zero_flag", {31'd0, zero_flag}, {31'd0, e == 32'd0});
`endif
      end
    end
  end

  // Entered at #1 after an edge. Leaves instr_valid high so that several calls
  // in a row form a continuous stream. track=0 means no write-back is expected.
  task automatic send(input logic [3:0] op, input logic [31:0] d,
                      input logic [31:0] e, input bit track);
    int n = 0;
    instr_valid = 1'b1;
    instr_opcode = op;
    instr_data = d;
    push_idx++;
    while (!instr_ready && n < 50) begin
      if (first_stall == 0) first_stall = push_idx;
      @(posedge execlk); #1;
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instr_ready=0 for %0d cycles, expected 1", n);
    end else if (track) begin
      exp_q.push_back(e);
    end
    @(posedge execlk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge execlk); #1;
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b pending=%0d, expected idle with 0 pending",
               busy, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Values held in reset
    repeat (3) @(posedge execlk);
    #1;
    chk("rst_acc_out", acc_out, 32'd0);
    chk("rst_alu_acc", alu_acc, 32'd0);
    chk("rst_alu_data", alu_data, 32'd0);
    chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("rst_zero_flag", {31'd0, zero_flag}, 32'd1);
`endif
    rst_n = 1'b1;
    @(posedge execlk); #1;

    // LDA 5 then ADD 3: checks latency, the EXEC view of alu_acc, and done spacing
    send(OP_LDA, 32'd5, 32'd5, 1'b1);   // accepted at E0
    send(OP_ADD, 32'd3, 32'd8, 1'b1);   // accepted at E1
    instr_valid = 1'b0;
    @(posedge execlk); #1;              // after E2
    chk("lat_acc_e2", acc_out, 32'd0);
    @(posedge execlk); #1;              // after E3
    chk("lat_acc_e3", acc_out, 32'd5);
    chk("lat_done_e3", {31'd0, done}, 32'd1);
    chk("exec_alu_acc", alu_acc, 32'd5);
    chk("exec_alu_data", alu_data, 32'd3);
    chk("exec_alu_opcode", {28'd0, alu_opcode}, {28'd0, OP_ADD});
    wait_idle();
    chk("done_gap", last_gap, 32'd2);
    chk("acc_after_add", acc_out, 32'd8);

    // Wrap below zero, then back to zero
    send(OP_SUB, 32'd10, 32'hFFFF_FFFE, 1'b1);
    send(OP_ADD, 32'd2, 32'd0, 1'b1);
    instr_valid = 1'b0;
    wait_idle();

    // An unmapped opcode leaves the accumulator unchanged but still writes back
    send(OP_LDA, 32'd4, 32'd4, 1'b1);
    send(OP_UNM, 32'd9, 32'd4, 1'b1);
    instr_valid = 1'b0;
    wait_idle();
    chk("unmapped_acc", acc_out, 32'd4);

    // Streaming ADD 1 with valid held high. The FIFO fills on the 7th push, so
    // the 8th request is the first to stall. The simultaneous push and pop
    // with 3 entries held must keep the count at 3 for that to happen.
    send(OP_LDA, 32'd0, 32'd0, 1'b1);
    instr_valid = 1'b0;
    wait_idle();
    first_stall = 0;
    push_idx = 0;
    for (int i = 1; i <= 8; i++) send(OP_ADD, 32'd1, i, 1'b1);
    instr_valid = 1'b0;
    wait_idle();
    chk("stream_first_stall", first_stall, 32'd8);
    chk("stream_acc", acc_out, 32'd8);

    // Reset during the EXEC cycle of ADD 7 while two requests are queued
    send(OP_ADD, 32'd0, 32'd0, 1'b0);   // E0; executes while the rest queue up
    send(OP_ADD, 32'd7, 32'd0, 1'b0);   // E1; popped at E3
    send(OP_ADD, 32'd1, 32'd0, 1'b0);   // E2
    send(OP_ADD, 32'd1, 32'd0, 1'b0);   // E3
    done_snap = done_cnt;
    chk("pre_reset_alu_data", alu_data, 32'd7);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("mid_rst_acc", acc_out, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(posedge execlk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge execlk);
    #1;
    chk("post_rst_no_done", done_cnt, done_snap);
    chk("post_rst_acc", acc_out, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Normal operation after the reset
    send(OP_ADD, 32'd5, 32'd5, 1'b1);
    instr_valid = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
